// File: rtl/sample_port_arbiter_if.sv
// Shared-sample-memory port bundle: four voice requesters, the memory read port and the return path.
interface sample_port_arbiter_if #(
  parameter int unsigned ADDR_W = 15,
  parameter int unsigned DATA_W = 16
);
  logic [3:0]          req;
  logic [4*ADDR_W-1:0] reqAddr;
  logic [3:0]          gnt;
  logic                memRden;
  logic [ADDR_W-1:0]   memAddr;
  logic [DATA_W-1:0]   memData;
  logic [DATA_W-1:0]   rdata;
  logic [3:0]          rvalid;

  // Master: voices plus memory model; slave: the arbiter
  modport master (
    output req, reqAddr, memData,
    input  gnt, memRden, memAddr, rdata, rvalid
  );

  modport slave (
    input  req, reqAddr, memData,
    output gnt, memRden, memAddr, rdata, rvalid
  );
endinterface

// File: rtl/sample_port_arbiter.sv
// Four-voice round-robin arbiter for one shared sample-memory read port, with a tag pipeline routing returns.
// Optional macro PRIORITY_BTN_EN: voice 0 gets fixed top priority, round-robin among voices 1..3.
module sample_port_arbiter #(
  parameter int unsigned ADDR_W  = 15,
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned MEM_LAT = 2
) (
  input logic                  clock,
  input logic                  reset,
  sample_port_arbiter_if.slave bus
);

`ifdef PRIORITY_BTN_EN
  localparam logic [1:0] PTR_RST = 2'd1;
`else
  localparam logic [1:0] PTR_RST = 2'd0;
`endif

  logic [1:0]         ptr;
  logic [1:0]         ptr_nxt;
  logic [1:0]         win;
  logic               win_vld;
  logic [1:0]         cand;
  logic [ADDR_W-1:0]  addr_q;
  logic [ADDR_W-1:0]  addr_win;
  logic [1:0]         tag_q [MEM_LAT];
  logic [MEM_LAT-1:0] vld_q;
  logic [3:0]         ret_vec;
`ifdef PRIORITY_BTN_EN
  logic [2:0]         span;
`endif

  // Pick the first requesting voice starting from ptr
  always_comb begin : arbitrate
    win     = 2'd0;
    win_vld = 1'b0;
    cand    = 2'd0;
`ifdef PRIORITY_BTN_EN
    span    = 3'd0;
    if (bus.req[0]) begin
      win_vld = 1'b1;
    end else begin
      for (int unsigned k = 0; k < 3; k++) begin
        // ptr lives in 1..3, so the search wraps 3 -> 1
        span = 3'(ptr) + 3'(k);
        if (span > 3'd3) span = span - 3'd3;
        cand = span[1:0];
        if (!win_vld && bus.req[cand]) begin
          win     = cand;
          win_vld = 1'b1;
        end
      end
    end
`else
    for (int unsigned k = 0; k < 4; k++) begin
      cand = ptr + 2'(k);
      if (!win_vld && bus.req[cand]) begin
        win     = cand;
        win_vld = 1'b1;
      end
    end
`endif
    if (reset) win_vld = 1'b0;
  end

  // Pointer advance past the winner
  always_comb begin : next_ptr
    ptr_nxt = ptr;
    if (win_vld) begin
`ifdef PRIORITY_BTN_EN
      if (win != 2'd0) ptr_nxt = (win == 2'd3) ? 2'd1 : win + 2'd1;
`else
      ptr_nxt = win + 2'd1;
`endif
    end
  end

  assign addr_win = bus.reqAddr[32'(win)*ADDR_W +: ADDR_W];
  assign ret_vec  = 4'b0001 << tag_q[MEM_LAT-1];

  always_comb begin : drive_outputs
    bus.gnt     = win_vld ? (4'b0001 << win) : 4'b0000;
    bus.memRden = win_vld;
    bus.memAddr = reset ? '0 : (win_vld ? addr_win : addr_q);
    bus.rvalid  = (vld_q[MEM_LAT-1] && !reset) ? ret_vec : 4'b0000;
    bus.rdata   = (|bus.rvalid) ? bus.memData : '0;
  end

  always_ff @(posedge clock) begin : ctrl_regs
    if (reset) begin
      ptr    <= PTR_RST;
      addr_q <= '0;
      vld_q  <= '0;
    end else begin
      ptr      <= ptr_nxt;
      vld_q[0] <= win_vld;
      for (int unsigned i = 1; i < MEM_LAT; i++) vld_q[i] <= vld_q[i-1];
      if (win_vld) addr_q <= addr_win;
    end
  end

  // Tags need no reset: the valid bits qualify them
  always_ff @(posedge clock) begin : tag_regs
    tag_q[0] <= win;
    for (int unsigned i = 1; i < MEM_LAT; i++) tag_q[i] <= tag_q[i-1];
  end

endmodule

// File: tb/tb_sample_port_arbiter.sv
// Randomized and directed bench for sample_port_arbiter against a queue-based reference model.
module tb_sample_port_arbiter;
  localparam int unsigned AW  = 15;
  localparam int unsigned DW  = 16;
  localparam int unsigned LAT = 2;
  localparam int unsigned AV  = 4*AW;
  localparam int unsigned VW  = 4 + 1 + AW + 4 + DW;
`ifdef PRIORITY_BTN_EN
  localparam int PTR0 = 1;
`else
  localparam int PTR0 = 0;
`endif

  logic clock;
  logic reset;
  sample_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  sample_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  int          m_ptr;
  logic [AW-1:0] m_addr;
  logic [3:0]  m_q[$];

  logic [DW-1:0] cur_mem;
  logic [3:0]    obs_gnt, obs_rvalid, exp_gnt, exp_rvalid;
  logic          obs_rden, exp_rden;
  logic [AW-1:0] obs_addr, exp_addr;
  logic [DW-1:0] obs_rdata, exp_rdata;
  logic [VW-1:0] obs_vec, exp_vec;

  // One cycle: drive after the edge, sample settled outputs, then advance the model
  task automatic step(input logic rst, input logic [3:0] r, input logic [AV-1:0] a);
    int w;
    int v;
    @(posedge clock);
    #1;
    reset        = rst;
    bus.req      = r;
    bus.reqAddr  = a;
    cur_mem      = DW'($urandom);
    bus.memData  = cur_mem;
    #1;
    w = -1;
    if (!rst) begin
`ifdef PRIORITY_BTN_EN
      if (r[0]) w = 0;
      else for (int k = 0; k < 3; k++) begin
        v = 1 + ((m_ptr - 1 + k) % 3);
        if (w < 0 && r[v]) w = v;
      end
`else
      for (int k = 0; k < 4; k++) begin
        v = (m_ptr + k) % 4;
        if (w < 0 && r[v]) w = v;
      end
`endif
    end
    exp_gnt    = (w >= 0) ? 4'(1 << w) : 4'd0;
    exp_rden   = (w >= 0);
    exp_addr   = rst ? '0 : ((w >= 0) ? a[w*AW +: AW] : m_addr);
    exp_rvalid = rst ? 4'd0 : m_q[0];
    exp_rdata  = (exp_rvalid != 4'd0) ? cur_mem : '0;
    obs_gnt    = bus.gnt;
    obs_rden   = bus.memRden;
    obs_addr   = bus.memAddr;
    obs_rvalid = bus.rvalid;
    obs_rdata  = bus.rdata;
    obs_vec    = {obs_gnt, obs_rden, obs_addr, obs_rvalid, obs_rdata};
    exp_vec    = {exp_gnt, exp_rden, exp_addr, exp_rvalid, exp_rdata};
    if (rst) begin
      m_ptr  = PTR0;
      m_addr = '0;
      m_q    = {};
      for (int i = 0; i < int'(LAT); i++) m_q.push_back(4'd0);
    end else begin
      if (w >= 0) begin
        m_addr = a[w*AW +: AW];
`ifdef PRIORITY_BTN_EN
        if (w != 0) m_ptr = 1 + (w % 3);
`else
        m_ptr = (w + 1) % 4;
`endif
      end
      void'(m_q.pop_front());
      m_q.push_back(exp_gnt);
    end
  endtask

  task automatic test_reset();
    for (int c = 0; c < 3; c++) begin
      step(1'b1, 4'($urandom), AV'({$urandom, $urandom}));
      n_checks++;
      if (obs_vec !== exp_vec) begin
        n_fail++;
        $display("FAIL reset_outputs: got %h required %h", obs_vec, exp_vec);
      end
    end
    step(1'b0, 4'b1000, AV'({$urandom, $urandom}));
    n_checks++;
    if (obs_gnt !== 4'b1000 || obs_rden !== 1'b1) begin
      n_fail++;
      $display("FAIL first_grant_after_reset: got gnt=%b rden=%b required gnt=1000 rden=1", obs_gnt, obs_rden);
    end
  endtask

  task automatic test_single();
    step(1'b1, 4'd0, '0);
    step(1'b0, 4'b0001, AV'(15'h0004));
    n_checks++;
    if (obs_gnt !== 4'b0001 || obs_rden !== 1'b1 || obs_addr !== AW'(4)) begin
      n_fail++;
      $display("FAIL single_grant: got gnt=%b rden=%b addr=%h required 0001 1 0004", obs_gnt, obs_rden, obs_addr);
    end
    for (int c = 1; c <= int'(LAT); c++) begin
      step(1'b0, 4'd0, '0);
      n_checks++;
      if (c == int'(LAT) && (obs_rvalid !== 4'b0001 || obs_rdata !== cur_mem)) begin
        n_fail++;
        $display("FAIL single_return: got rvalid=%b rdata=%h required 0001 %h", obs_rvalid, obs_rdata, cur_mem);
      end else if (c != int'(LAT) && obs_rvalid !== 4'b0000) begin
        n_fail++;
        $display("FAIL single_early_return: got rvalid=%b required 0000", obs_rvalid);
      end
      n_checks++;
      if (obs_addr !== AW'(4)) begin
        n_fail++;
        $display("FAIL single_addr_hold: got %h required 0004", obs_addr);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] seq [16];
    step(1'b1, 4'd0, '0);
    for (int k = 0; k < 8 + int'(LAT); k++) begin
`ifdef PRIORITY_BTN_EN
      seq[k] = (k < 8) ? 4'b0001 : 4'b0000;
`else
      seq[k] = (k < 8) ? 4'(1 << (k % 4)) : 4'b0000;
`endif
      step(1'b0, (k < 8) ? 4'b1111 : 4'b0000, AV'({$urandom, $urandom}));
      n_checks++;
      if (obs_gnt !== seq[k]) begin
        n_fail++;
        $display("FAIL b2b_gnt[%0d]: got %b required %b", k, obs_gnt, seq[k]);
      end
      n_checks++;
      if (obs_rvalid !== ((k >= int'(LAT)) ? seq[k-int'(LAT)] : 4'b0000)) begin
        n_fail++;
        $display("FAIL b2b_rvalid[%0d]: got %b required %b", k, obs_rvalid,
                 (k >= int'(LAT)) ? seq[k-int'(LAT)] : 4'b0000);
      end
      n_checks++;
      if (obs_vec !== exp_vec) begin
        n_fail++;
        $display("FAIL b2b_model[%0d]: got %h required %h", k, obs_vec, exp_vec);
      end
    end
  endtask

  task automatic test_wrap();
    logic [3:0] rq [3];
    logic [3:0] gq [3];
    rq[0] = 4'b0100; rq[1] = 4'b0011; rq[2] = 4'b0010;
    gq[0] = 4'b0100; gq[1] = 4'b0001; gq[2] = 4'b0010;
    step(1'b1, 4'd0, '0);
    for (int k = 0; k < 3; k++) begin
      step(1'b0, rq[k], AV'({$urandom, $urandom}));
      n_checks++;
      if (obs_gnt !== gq[k] || obs_vec !== exp_vec) begin
        n_fail++;
        $display("FAIL wrap[%0d]: got gnt=%b vec=%h required gnt=%b vec=%h", k, obs_gnt, obs_vec, gq[k], exp_vec);
      end
    end
  endtask

  task automatic test_reset_mid();
    step(1'b1, 4'd0, '0);
    step(1'b0, 4'b0010, AV'({$urandom, $urandom}));
    step(1'b0, 4'b0100, AV'({$urandom, $urandom}));
    step(1'b1, 4'b0000, '0);
    step(1'b0, 4'b1001, AV'({$urandom, $urandom}));
    n_checks++;
    if (obs_gnt !== 4'b0001) begin
      n_fail++;
      $display("FAIL reset_mid_next_gnt: got %b required 0001", obs_gnt);
    end
    for (int c = 0; c < int'(LAT) + 2; c++) begin
      step(1'b0, 4'd0, '0);
      n_checks++;
      if ((obs_rvalid & 4'b0110) !== 4'b0000 || obs_vec !== exp_vec) begin
        n_fail++;
        $display("FAIL reset_mid_flush[%0d]: got rvalid=%b vec=%h required vec=%h", c, obs_rvalid, obs_vec, exp_vec);
      end
    end
  endtask

  task automatic test_priority();
`ifdef PRIORITY_BTN_EN
    logic [3:0] gq [4];
    gq[0] = 4'b0010; gq[1] = 4'b0100; gq[2] = 4'b1000; gq[3] = 4'b0010;
    step(1'b1, 4'd0, '0);
    for (int k = 0; k < 6; k++) begin
      step(1'b0, 4'b1111, AV'({$urandom, $urandom}));
      n_checks++;
      if (obs_gnt !== 4'b0001) begin
        n_fail++;
        $display("FAIL prio_voice0[%0d]: got %b required 0001", k, obs_gnt);
      end
    end
    for (int k = 0; k < 4; k++) begin
      step(1'b0, 4'b1110, AV'({$urandom, $urandom}));
      n_checks++;
      if (obs_gnt !== gq[k]) begin
        n_fail++;
        $display("FAIL prio_rr[%0d]: got %b required %b", k, obs_gnt, gq[k]);
      end
    end
`endif
  endtask

  task automatic test_random();
    logic rst;
    step(1'b1, 4'd0, '0);
    for (int k = 0; k < 600; k++) begin
      rst = ($urandom_range(0, 49) == 0);
      step(rst, 4'($urandom), AV'({$urandom, $urandom}));
      n_checks++;
      if (obs_vec !== exp_vec) begin
        n_fail++;
        $display("FAIL random[%0d]: got gnt=%b rden=%b addr=%h rvalid=%b rdata=%h required gnt=%b rden=%b addr=%h rvalid=%b rdata=%h",
                 k, obs_gnt, obs_rden, obs_addr, obs_rvalid, obs_rdata,
                 exp_gnt, exp_rden, exp_addr, exp_rvalid, exp_rdata);
      end
    end
  endtask

  initial begin
    reset       = 1'b1;
    bus.req     = 4'd0;
    bus.reqAddr = '0;
    bus.memData = '0;
    m_ptr       = PTR0;
    m_addr      = '0;
    for (int i = 0; i < int'(LAT); i++) m_q.push_back(4'd0);
    test_reset();
    test_single();
    test_back_to_back();
    test_wrap();
    test_reset_mid();
    test_priority();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/sample_port_arbiter.md
SAMPLE_PORT_ARBITER -- requirements
Module: sample_port_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 15, meaning the sample-memory address width (matches the WaveMaker address).
REQ-002 The block SHALL have parameter DATA_W, default 16, meaning the sample-memory data width.
REQ-003 The block SHALL have parameter MEM_LAT, default 2, legal range 1..4, meaning the memory read latency in cycles from memRden to memData valid.
REQ-004 The block SHALL have port clock, input, 1, the single system clock; all logic is on its rising edge.
REQ-005 The block SHALL have port reset, input, 1, a synchronous active-high reset.
REQ-006 The block SHALL have port req, input, 4, per-voice read request, held high until granted.
REQ-007 The block SHALL have port reqAddr, input, 4*ADDR_W, per-voice address, voice i in bits [i*ADDR_W +: ADDR_W], stable while req[i] is high.
REQ-008 The block SHALL have port gnt, output, 4, a one-hot single-cycle pulse accepting the request of voice i.
REQ-009 The block SHALL have port memRden, output, 1, the shared memory read enable.
REQ-010 The block SHALL have port memAddr, output, ADDR_W, the shared memory address.
REQ-011 The block SHALL have port memData, input, DATA_W, the memory read data, valid MEM_LAT cycles after memRden.
REQ-012 The block SHALL have port rdata, output, DATA_W, the returned sample.
REQ-013 The block SHALL have port rvalid, output, 4, one-hot, marking which voice owns rdata this cycle.

Function
REQ-014 The block SHALL issue at most one grant per cycle, combinationally from req and the priority pointer; gnt, memRden and memAddr are asserted in the same cycle.
REQ-015 Arbitration SHALL be round-robin: the search starts at voice ptr, ascending with wrap 3->0, and the first voice with req high wins.
REQ-016 After a grant to voice i, ptr SHALL become (i+1) mod 4 on the next edge; with no grant, ptr SHALL hold.
REQ-017 When req is 0, gnt SHALL be 0, memRden SHALL be 0, and memAddr SHALL hold its last registered value.
REQ-018 The block SHALL track the winner's index through a MEM_LAT-deep tag pipeline with a valid bit per stage, so that rvalid[i] is high exactly MEM_LAT cycles after gnt[i].
REQ-019 rdata SHALL equal memData, passed through combinationally, whenever any rvalid bit is set, and SHALL be 0 otherwise.
REQ-020 Grants SHALL be issuable back-to-back every cycle; returns SHALL be fully pipelined with no stall.
REQ-021 A requester dropping req without a grant SHALL be legal; it is simply not served.
REQ-022 With all four voices continuously requesting, each voice SHALL receive exactly one grant in every 4 consecutive cycles.

Reset
REQ-023 While reset is high: gnt=0, memRden=0, memAddr=0, rvalid=0, rdata=0, ptr=0, and all tag-pipeline valid bits are cleared.
REQ-024 A reset asserted mid-operation SHALL discard all in-flight reads; no rvalid is produced for grants issued before or during reset.
REQ-025 The first grant SHALL be possible in the first cycle after reset is low.

Configuration
REQ-026 Macro PRIORITY_BTN_EN: when defined, voice 0 (the live-button voice) SHALL have fixed highest priority, and it wins whenever req[0]=1. The round-robin of REQ-015 applies only among voices 1..3; ptr ranges over 1..3, resets to 1, and after a grant to voice 3 becomes 1.
REQ-027 When PRIORITY_BTN_EN is not defined, all four voices SHALL be in plain round-robin per REQ-015..REQ-016.

Verification
REQ-028 Scenario (after reset): req=0001, reqAddr0=0x0004 -> gnt=0001, memRden=1, memAddr=0x0004 in the same cycle; rvalid=0001 and rdata=memData exactly 2 cycles later.
REQ-029 Scenario: req=1111 held for 8 cycles, macro off -> gnt sequence 0001,0010,0100,1000,0001,0010,0100,1000; rvalid follows the same sequence delayed by 2.
REQ-030 Scenario: after a grant to voice 2, req=0011 -> gnt=0001 (wrap from ptr=3), then ptr=1 and next gnt=0010.
REQ-031 Scenario: reset pulsed one cycle after grants to voices 1 and 2 -> rvalid stays 0 for both; next gnt goes to the lowest requesting voice (voice 0 with the macro off; voice 0 if requesting, otherwise voice 1, with the macro on).
REQ-032 Scenario: PRIORITY_BTN_EN defined, req=1111 held 6 cycles -> gnt=0001 every cycle; then req=1110 -> gnt sequence 0010,0100,1000,0010.
REQ-033 Scenario: MEM_LAT=1 and MEM_LAT=4 builds, req=0100 pulsed -> rvalid=0100 exactly 1 and 4 cycles after gnt, respectively.
